// File: rtl/mul_result_reorder.sv
// ----------------------------------------------------------------------------
// mul_result_reorder
// Tags every mul issued into the 3-stage multiplier, captures the out-of-order
// completions from the E, M and W stages, and retires the results to
// writeback strictly in issue order over a valid/ready handshake.
//
// Ports
//   clk, rst        core clock; asynchronous active-high reset
//   flush           synchronous discard of all in-flight entries
//   issue_*         issue request, destination register, free-slot flag, tag
//   cmp_*_{e,m,w}   per-stage completion (valid, tag, result)
//   wb_*            in-order writeback (valid, rd, data, ready)
//   count           number of occupied entries
//   err             sticky flag for a completion that matched no pending op
// ----------------------------------------------------------------------------
module mul_result_reorder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = $clog2(DEPTH),
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             issue_valid,
   input  logic [RD_W-1:0]  issue_rd,
   output logic             issue_ready,
   output logic [TAG_W-1:0] issue_tag,
   input  logic             cmp_valid_e,
   input  logic [TAG_W-1:0] cmp_tag_e,
   input  logic [XLEN-1:0]  cmp_data_e,
   input  logic             cmp_valid_m,
   input  logic [TAG_W-1:0] cmp_tag_m,
   input  logic [XLEN-1:0]  cmp_data_m,
   input  logic             cmp_valid_w,
   input  logic [TAG_W-1:0] cmp_tag_w,
   input  logic [XLEN-1:0]  cmp_data_w,
   output logic             wb_valid,
   output logic [RD_W-1:0]  wb_rd,
   output logic [XLEN-1:0]  wb_data,
   input  logic             wb_ready,
   output logic [TAG_W:0]   count,
   output logic             err
);

   localparam int unsigned CNT_W  = TAG_W + 1;
   localparam int unsigned NSTAGE = 3;

   // Entry storage
   logic             busy_q [DEPTH];
   logic             busy_d [DEPTH];
   logic             done_q [DEPTH];
   logic             done_d [DEPTH];
   logic [RD_W-1:0]  rd_q   [DEPTH];
   logic [RD_W-1:0]  rd_d   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [XLEN-1:0]  data_d [DEPTH];

   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   // Completion ports gathered so they can be processed in one loop (0=E,1=M,2=W)
   logic [NSTAGE-1:0]            cv_c;
   logic [NSTAGE-1:0][TAG_W-1:0] ct_c;
   logic [NSTAGE-1:0][XLEN-1:0]  cd_c;

   logic issue_fire_c;
   logic retire_fire_c;
   logic head_ready_c;

   assign cv_c = {cmp_valid_w, cmp_valid_m, cmp_valid_e};
   assign ct_c = {cmp_tag_w,   cmp_tag_m,   cmp_tag_e};
   assign cd_c = {cmp_data_w,  cmp_data_m,  cmp_data_e};

   // Head is presentable when its result has arrived; flush suppresses it
   assign head_ready_c  = busy_q[head_q] & done_q[head_q];
   assign issue_ready   = (count_q != CNT_W'(DEPTH));
   assign issue_tag     = tail_q;
   assign wb_valid      = head_ready_c & ~flush;
   assign wb_rd         = wb_valid ? rd_q[head_q]   : '0;
   assign wb_data       = wb_valid ? data_q[head_q] : '0;
   assign count         = count_q;
   assign err           = err_q;

   assign issue_fire_c  = issue_valid & issue_ready & ~flush;
   assign retire_fire_c = wb_valid & wb_ready;

   // Next-state: flush wins; otherwise retire head, issue at tail, apply completions
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         busy_d[i] = busy_q[i];
         done_d[i] = done_q[i];
         rd_d[i]   = rd_q[i];
         data_d[i] = data_q[i];
      end
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q;

      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_d[i] = 1'b0;
            done_d[i] = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (retire_fire_c) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + TAG_W'(1);
         end

         // The tail slot is always free when issue fires, so it never aliases head
         if (issue_fire_c) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            rd_d[tail_q]   = issue_rd;
            tail_d         = tail_q + TAG_W'(1);
         end

         // A completion is legal for a pending entry or the one issuing this cycle;
         // a hit on a retiring head counts as already done, hence stray
         for (int unsigned s = 0; s < NSTAGE; s++) begin
            if (cv_c[s]) begin
               if ((busy_q[ct_c[s]] && !done_q[ct_c[s]]) ||
                   (issue_fire_c && (ct_c[s] == tail_q))) begin
                  done_d[ct_c[s]] = 1'b1;
                  data_d[ct_c[s]] = cd_c[s];
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         count_d = count_q + CNT_W'(issue_fire_c) - CNT_W'(retire_fire_c);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_q[i] <= 1'b0;
            done_q[i] <= 1'b0;
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_q[i] <= busy_d[i];
            done_q[i] <= done_d[i];
            rd_q[i]   <= rd_d[i];
            data_q[i] <= data_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mul_result_reorder.sv
// ----------------------------------------------------------------------------
// tb_mul_result_reorder
// Self-checking bench: an in-order queue model of the reorder buffer predicts
// every output each cycle; directed scenarios add literal expectations, and a
// randomized phase drives legal out-of-order completions, backpressure,
// flushes and a mid-run reset.
// ----------------------------------------------------------------------------
module tb_mul_result_reorder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [1:0]  issue_tag;
   logic        cmp_valid_e, cmp_valid_m, cmp_valid_w;
   logic [1:0]  cmp_tag_e, cmp_tag_m, cmp_tag_w;
   logic [31:0] cmp_data_e, cmp_data_m, cmp_data_w;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic [2:0]  count;
   logic        err;

   int checks = 0;
   int errors = 0;

   mul_result_reorder dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .issue_tag   (issue_tag),
      .cmp_valid_e (cmp_valid_e),
      .cmp_tag_e   (cmp_tag_e),
      .cmp_data_e  (cmp_data_e),
      .cmp_valid_m (cmp_valid_m),
      .cmp_tag_m   (cmp_tag_m),
      .cmp_data_m  (cmp_data_m),
      .cmp_valid_w (cmp_valid_w),
      .cmp_tag_w   (cmp_tag_w),
      .cmp_data_w  (cmp_data_w),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .count       (count),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Model: ops in issue order; tag of element i is (head + i) mod DEPTH
   typedef struct {
      logic [4:0]  rd;
      bit          done;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   tail_m;
   bit   err_m;

   function automatic int head_m();
      return (tail_m - mq.size() + 2 * DEPTH) % DEPTH;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      cmp_valid_e = 1'b0; cmp_tag_e = '0; cmp_data_e = '0;
      cmp_valid_m = 1'b0; cmp_tag_m = '0; cmp_data_m = '0;
      cmp_valid_w = 1'b0; cmp_tag_w = '0; cmp_data_w = '0;
      wb_ready    = 1'b0;
   endtask

   task automatic model_check();
      bit          ev;
      logic [4:0]  erd;
      logic [31:0] edata;
      ev    = !flush && (mq.size() > 0) && mq[0].done;
      erd   = ev ? mq[0].rd   : 5'd0;
      edata = ev ? mq[0].data : 32'd0;
      chk("m_wb_valid",    64'(wb_valid),    64'(ev));
      chk("m_wb_rd",       64'(wb_rd),       64'(erd));
      chk("m_wb_data",     64'(wb_data),     64'(edata));
      chk("m_count",       64'(count),       64'(mq.size()));
      chk("m_issue_ready", 64'(issue_ready), 64'(mq.size() != DEPTH));
      chk("m_issue_tag",   64'(issue_tag),   64'(tail_m));
      chk("m_err",         64'(err),         64'(err_m));
   endtask

   task automatic model_update();
      bit          ret, iss;
      ent_t        ne, e;
      int          idx, hd;
      bit          cv [3];
      int          ct [3];
      logic [31:0] cd [3];
      if (flush) begin
         mq.delete();
         tail_m = 0;
         return;
      end
      cv[0] = cmp_valid_e; ct[0] = int'(cmp_tag_e); cd[0] = cmp_data_e;
      cv[1] = cmp_valid_m; ct[1] = int'(cmp_tag_m); cd[1] = cmp_data_m;
      cv[2] = cmp_valid_w; ct[2] = int'(cmp_tag_w); cd[2] = cmp_data_w;
      ret = (mq.size() > 0) && mq[0].done && wb_ready;
      iss = issue_valid && (mq.size() < DEPTH);
      ne.rd = issue_rd; ne.done = 1'b0; ne.data = '0;
      hd = head_m();
      for (int s = 0; s < 3; s++) begin
         if (cv[s]) begin
            idx = (ct[s] - hd + DEPTH) % DEPTH;
            if (idx < mq.size() && !mq[idx].done) begin
               e = mq[idx]; e.done = 1'b1; e.data = cd[s]; mq[idx] = e;
            end else if (iss && ct[s] == tail_m) begin
               ne.done = 1'b1; ne.data = cd[s];
            end else begin
               err_m = 1'b1;
            end
         end
      end
      if (ret) void'(mq.pop_front());
      if (iss) begin
         mq.push_back(ne);
         tail_m = (tail_m + 1) % DEPTH;
      end
   endtask

   // One clock: compare against the model, advance the model, move to next negedge
   task automatic cycle();
      #1;
      model_check();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      #1;
      mq.delete();
      tail_m = 0;
      err_m  = 1'b0;
      chk("rst_issue_ready", 64'(issue_ready), 64'd1);
      chk("rst_issue_tag",   64'(issue_tag),   64'd0);
      chk("rst_wb_valid",    64'(wb_valid),    64'd0);
      chk("rst_count",       64'(count),       64'd0);
      chk("rst_err",         64'(err),         64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Random legal stimulus derived from the model's view of pending ops
   task automatic rand_inputs();
      int   cand[$];
      int   k, hd;
      bit   will_iss;
      idle();
      flush       = ($urandom_range(0, 99) < 3);
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_rd    = 5'($urandom);
      wb_ready    = ($urandom_range(0, 99) < 70);
      will_iss    = issue_valid && (mq.size() < DEPTH);
      hd = head_m();
      for (int i = 0; i < mq.size(); i++)
         if (!mq[i].done) cand.push_back((hd + i) % DEPTH);
      if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
         k = $urandom_range(0, cand.size() - 1);
         cmp_valid_w = 1'b1; cmp_tag_w = 2'(cand[k]); cmp_data_w = $urandom;
         cand.delete(k);
      end
      if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
         k = $urandom_range(0, cand.size() - 1);
         cmp_valid_m = 1'b1; cmp_tag_m = 2'(cand[k]); cmp_data_m = $urandom;
         cand.delete(k);
      end
      if (will_iss) cand.push_back(tail_m);
      if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
         k = $urandom_range(0, cand.size() - 1);
         cmp_valid_e = 1'b1; cmp_tag_e = 2'(cand[k]); cmp_data_e = $urandom;
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      @(negedge clk);

      // In-order 3-cycle op
      do_reset();
      idle(); issue_valid = 1'b1; issue_rd = 5'd5;
      #1 chk("io_issue_tag", 64'(issue_tag), 64'd0);
      cycle();
      idle(); cycle();
      idle(); cmp_valid_w = 1'b1; cmp_tag_w = 2'd0; cmp_data_w = 32'h1234;
      #1 chk("io_wb_early", 64'(wb_valid), 64'd0);
      cycle();
      idle(); wb_ready = 1'b1;
      #1 chk("io_wb_valid", 64'(wb_valid), 64'd1);
      chk("io_wb_rd",   64'(wb_rd),   64'd5);
      chk("io_wb_data", 64'(wb_data), 64'h1234);
      cycle();
      idle();
      #1 chk("io_count", 64'(count), 64'd0);
      cycle();

      // Out-of-order completion, retired in issue order
      do_reset();
      idle(); issue_valid = 1'b1; issue_rd = 5'd1; cycle();
      idle(); issue_valid = 1'b1; issue_rd = 5'd2;
      cmp_valid_e = 1'b1; cmp_tag_e = 2'd1; cmp_data_e = 32'hBBBB; cycle();
      idle(); cmp_valid_w = 1'b1; cmp_tag_w = 2'd0; cmp_data_w = 32'hAAAA;
      #1 chk("ooo_head_blocked", 64'(wb_valid), 64'd0);
      cycle();
      idle(); wb_ready = 1'b1;
      #1 chk("ooo_rd0", 64'(wb_rd), 64'd1);
      chk("ooo_data0", 64'(wb_data), 64'hAAAA);
      cycle();
      idle(); wb_ready = 1'b1;
      #1 chk("ooo_rd1", 64'(wb_rd), 64'd2);
      chk("ooo_data1", 64'(wb_data), 64'hBBBB);
      cycle();

      // Full buffer
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         idle(); issue_valid = 1'b1; issue_rd = 5'(10 + i); cycle();
      end
      idle(); issue_valid = 1'b1; issue_rd = 5'd31;
      #1 chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(issue_ready), 64'd0);
      chk("full_tag",   64'(issue_tag),   64'd0);
      cycle();
      idle(); cmp_valid_e = 1'b1; cmp_tag_e = 2'd0; cmp_data_e = 32'h55;
      #1 chk("full_tag_held", 64'(issue_tag), 64'd0);
      cycle();
      idle(); wb_ready = 1'b1;
      #1 chk("full_wb_rd", 64'(wb_rd), 64'd10);
      chk("full_ready_in_retire", 64'(issue_ready), 64'd0);
      cycle();
      idle();
      #1 chk("full_ready_after", 64'(issue_ready), 64'd1);
      chk("full_count_after", 64'(count), 64'd3);
      cycle();

      // Backpressure holds the head stable
      do_reset();
      idle(); issue_valid = 1'b1; issue_rd = 5'd7; cycle();
      idle(); issue_valid = 1'b1; issue_rd = 5'd8;
      cmp_valid_w = 1'b1; cmp_tag_w = 2'd0; cmp_data_w = 32'h77; cycle();
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i == 0) begin
            cmp_valid_m = 1'b1; cmp_tag_m = 2'd1; cmp_data_m = 32'h88;
         end
         #1 chk("bp_rd",   64'(wb_rd),   64'd7);
         chk("bp_data", 64'(wb_data), 64'h77);
         cycle();
      end
      idle(); wb_ready = 1'b1; cycle();
      idle(); wb_ready = 1'b1;
      #1 chk("bp_next_rd", 64'(wb_rd), 64'd8);
      chk("bp_next_data", 64'(wb_data), 64'h88);
      cycle();

      // Flush, then a stray completion sets the sticky error
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle(); issue_valid = 1'b1; issue_rd = 5'(20 + i);
         if (i == 2) begin
            cmp_valid_e = 1'b1; cmp_tag_e = 2'd0; cmp_data_e = 32'h99;
         end
         cycle();
      end
      idle(); flush = 1'b1; issue_valid = 1'b1; wb_ready = 1'b1;
      cmp_valid_m = 1'b1; cmp_tag_m = 2'd1; cmp_data_m = 32'h1;
      #1 chk("fl_wb_masked", 64'(wb_valid), 64'd0);
      cycle();
      idle(); cmp_valid_m = 1'b1; cmp_tag_m = 2'd2; cmp_data_m = 32'hDEAD;
      #1 chk("fl_count", 64'(count), 64'd0);
      chk("fl_err_clear", 64'(err), 64'd0);
      cycle();
      idle(); flush = 1'b1;
      #1 chk("stray_err", 64'(err), 64'd1);
      cycle();
      idle();
      #1 chk("err_sticky", 64'(err), 64'd1);
      cycle();

      // Randomized traffic with a reset in the middle of operation
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (c == 300) do_reset();
         rand_inputs();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
